// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM states, requester
// indices, bus widths and a saturating counter helper.
package dmem_arbiter_pkg;

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_BURST = 1'b1
    } st_e;

    localparam int REQ_CORE = 0;
    localparam int REQ_DMA  = 1;

    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;
    localparam int STB_W  = 4;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// slave = arbiter view; master = requesters plus memory view.
interface dmem_arbiter_if;
    import dmem_arbiter_pkg::*;

    logic              C_REQ, C_WE, C_GNT, C_STALL, C_RVALID;
    logic [ADDR_W-1:0] C_ADDR;
    logic [DATA_W-1:0] C_WDATA;
    logic [STB_W-1:0]  C_WSTB;

    logic              D_REQ, D_WE, D_LOCK, D_GNT, D_RVALID;
    logic [ADDR_W-1:0] D_ADDR;
    logic [DATA_W-1:0] D_WDATA;
    logic [STB_W-1:0]  D_WSTB;

    logic [DATA_W-1:0] RDATA;
    logic [ADDR_W-1:0] MADDR;
    logic [DATA_W-1:0] MDATAO;
    logic [STB_W-1:0]  MWSTB;
    logic              CEM;
    logic [DATA_W-1:0] MDATAI;

    modport slave (
        input  C_REQ, C_WE, C_ADDR, C_WDATA, C_WSTB,
        input  D_REQ, D_WE, D_ADDR, D_WDATA, D_WSTB, D_LOCK,
        input  MDATAI,
        output C_GNT, C_STALL, C_RVALID, D_GNT, D_RVALID,
        output RDATA, MADDR, MDATAO, MWSTB, CEM
    );

    modport master (
        output C_REQ, C_WE, C_ADDR, C_WDATA, C_WSTB,
        output D_REQ, D_WE, D_ADDR, D_WDATA, D_WSTB, D_LOCK,
        output MDATAI,
        input  C_GNT, C_STALL, C_RVALID, D_GNT, D_RVALID,
        input  RDATA, MADDR, MDATAO, MWSTB, CEM
    );

endinterface

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the core (fixed priority) and the DMA engine,
// with starvation relief for DMA and bounded DMA burst ownership.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int MAX_BURST    = 4
) (
    input  logic          CLK,
    input  logic          RSTN,
    dmem_arbiter_if.slave bus
);

    localparam logic [7:0] STARVE_L = 8'(STARVE_LIMIT);
    localparam logic [7:0] MAX_B    = 8'(MAX_BURST);

    st_e        r_st, w_st_nxt;
    logic [7:0] r_wait_cnt, w_wait_nxt;
    logic [7:0] r_burst_cnt, w_burst_nxt;
    logic       r_hog, w_hog_nxt;
    logic [1:0] r_rd_own;
    logic       w_c_gnt, w_d_gnt;
    logic       w_starved;
    logic [7:0] w_burst_inc;

    assign w_starved   = bus.D_REQ && (r_wait_cnt >= STARVE_L);
    assign w_burst_inc = (r_st == ST_BURST) ? r_burst_cnt + 8'd1 : 8'd1;

    always_comb begin
        w_c_gnt     = 1'b0;
        w_d_gnt     = 1'b0;
        w_st_nxt    = r_st;
        w_burst_nxt = r_burst_cnt;
        w_hog_nxt   = 1'b0;
        w_wait_nxt  = '0;
        if (RSTN) begin
            unique case (r_st)
                ST_ARB: begin
                    // r_hog: one-cycle core precedence right after a full-length burst
                    w_c_gnt = bus.C_REQ && (r_hog || !w_starved);
                    w_d_gnt = bus.D_REQ && !w_c_gnt;
                end
                ST_BURST: begin
                    w_d_gnt = bus.D_REQ;
                    w_c_gnt = bus.C_REQ && !bus.D_REQ;
                end
                default: ;
            endcase

            if (w_d_gnt && ((r_st == ST_BURST) || bus.D_LOCK)) begin
                if (w_burst_inc == MAX_B) begin
                    w_st_nxt    = ST_ARB;
                    w_burst_nxt = '0;
                    w_hog_nxt   = 1'b1;
                end else if (!bus.D_LOCK) begin
                    w_st_nxt    = ST_ARB;
                    w_burst_nxt = '0;
                end else begin
                    w_st_nxt    = ST_BURST;
                    w_burst_nxt = w_burst_inc;
                end
            end

            if (bus.D_REQ && !w_d_gnt) begin
                w_wait_nxt = sat_inc8(r_wait_cnt);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_st        <= ST_ARB;
            r_wait_cnt  <= '0;
            r_burst_cnt <= '0;
            r_hog       <= 1'b0;
            r_rd_own    <= '0;
        end else begin
            r_st               <= w_st_nxt;
            r_wait_cnt         <= w_wait_nxt;
            r_burst_cnt        <= w_burst_nxt;
            r_hog              <= w_hog_nxt;
            r_rd_own[REQ_CORE] <= w_c_gnt && !bus.C_WE;
            r_rd_own[REQ_DMA]  <= w_d_gnt && !bus.D_WE;
        end
    end

    assign bus.C_GNT   = w_c_gnt;
    assign bus.D_GNT   = w_d_gnt;
    assign bus.C_STALL = bus.C_REQ && !w_c_gnt;
    assign bus.CEM     = w_c_gnt || w_d_gnt;

    assign bus.MADDR  = w_c_gnt ? bus.C_ADDR  : (w_d_gnt ? bus.D_ADDR  : '0);
    assign bus.MDATAO = w_c_gnt ? bus.C_WDATA : (w_d_gnt ? bus.D_WDATA : '0);
    assign bus.MWSTB  = (w_c_gnt && bus.C_WE) ? bus.C_WSTB :
                        ((w_d_gnt && bus.D_WE) ? bus.D_WSTB : '0);

    // A response still in flight when reset is asserted is suppressed immediately
    assign bus.C_RVALID = r_rd_own[REQ_CORE] && RSTN;
    assign bus.D_RVALID = r_rd_own[REQ_DMA] && RSTN;
    assign bus.RDATA    = bus.MDATAI;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural arbitration/memory model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int STARVE = 8;
    localparam int MAXB   = 4;
    localparam int NWORDS = 256;

    logic CLK  = 1'b0;
    logic RSTN = 1'b0;

    dmem_arbiter_if bus();

    dmem_arbiter #(.STARVE_LIMIT(STARVE), .MAX_BURST(MAXB)) dut (
        .CLK (CLK),
        .RSTN(RSTN),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem     [NWORDS];
    logic [31:0] ref_mem [NWORDS];

    // model state
    int          m_wait  = 0;
    int          m_burst = 0;
    bit          m_hog   = 1'b0;
    bit          m_rc    = 1'b0;
    bit          m_rd    = 1'b0;
    logic [31:0] m_rdata_c, m_rdata_d;
    bit          last_c = 1'b0;
    bit          last_d = 1'b0;

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE0000 ^ (32'(i) * 32'h00010101);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] stb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (stb[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic c_set(input bit req, input bit we, input logic [29:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        bus.C_REQ = req; bus.C_WE = we; bus.C_ADDR = a; bus.C_WDATA = d; bus.C_WSTB = s;
    endtask

    task automatic d_set(input bit req, input bit we, input bit lock, input logic [29:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        bus.D_REQ = req; bus.D_WE = we; bus.D_LOCK = lock;
        bus.D_ADDR = a; bus.D_WDATA = d; bus.D_WSTB = s;
    endtask

    // data memory: registered read, byte-strobed write
    initial begin
        for (int i = 0; i < NWORDS; i++) mem[i] = init_word(i);
        forever begin
            @(posedge CLK);
            if (bus.CEM) begin
                if (bus.MWSTB != 4'b0000)
                    mem[bus.MADDR[7:0]] <= merge(mem[bus.MADDR[7:0]], bus.MDATAO, bus.MWSTB);
                else
                    bus.MDATAI <= mem[bus.MADDR[7:0]];
            end
        end
    end

    // reference model and per-cycle compare
    initial begin
        bit          ec, ed;
        logic [29:0] ea;
        logic [31:0] eo;
        logic [3:0]  es;
        bit          hog_n;
        for (int i = 0; i < NWORDS; i++) ref_mem[i] = init_word(i);
        forever begin
            @(negedge CLK);
            ec = 1'b0; ed = 1'b0;
            if (RSTN) begin
                if (m_burst > 0) begin
                    ed = bus.D_REQ;
                    ec = bus.C_REQ && !bus.D_REQ;
                end else begin
                    ec = bus.C_REQ && (m_hog || !(bus.D_REQ && m_wait >= STARVE));
                    ed = bus.D_REQ && !ec;
                end
            end
            ea = '0; eo = '0; es = '0;
            if (ec) begin
                ea = bus.C_ADDR; eo = bus.C_WDATA; es = bus.C_WE ? bus.C_WSTB : 4'b0000;
            end else if (ed) begin
                ea = bus.D_ADDR; eo = bus.D_WDATA; es = bus.D_WE ? bus.D_WSTB : 4'b0000;
            end

            chk("grants", {bus.C_GNT, bus.D_GNT}, {ec, ed});
            chk("mem_port", {bus.CEM, bus.MADDR, bus.MDATAO, bus.MWSTB}, {ec | ed, ea, eo, es});
            chk("stall", bus.C_STALL, bus.C_REQ && !ec);
            chk("rvalid", {bus.D_RVALID, bus.C_RVALID}, {m_rd && RSTN, m_rc && RSTN});
            if (RSTN && m_rc) chk("c_rdata", bus.RDATA, m_rdata_c);
            if (RSTN && m_rd) chk("d_rdata", bus.RDATA, m_rdata_d);

            if (!RSTN) begin
                m_wait = 0; m_burst = 0; m_hog = 1'b0; m_rc = 1'b0; m_rd = 1'b0;
            end else begin
                hog_n = 1'b0;
                if (ed && (m_burst > 0 || bus.D_LOCK)) begin
                    if (m_burst + 1 == MAXB) begin
                        m_burst = 0;
                        hog_n   = 1'b1;
                    end else if (!bus.D_LOCK) begin
                        m_burst = 0;
                    end else begin
                        m_burst = m_burst + 1;
                    end
                end
                m_hog  = hog_n;
                m_wait = (bus.D_REQ && !ed) ? ((m_wait < 255) ? m_wait + 1 : 255) : 0;
                m_rc   = ec && !bus.C_WE;
                m_rd   = ed && !bus.D_WE;
                if (m_rc) m_rdata_c = ref_mem[bus.C_ADDR[7:0]];
                if (m_rd) m_rdata_d = ref_mem[bus.D_ADDR[7:0]];
                if (ec && bus.C_WE)
                    ref_mem[bus.C_ADDR[7:0]] = merge(ref_mem[bus.C_ADDR[7:0]], bus.C_WDATA, bus.C_WSTB);
                if (ed && bus.D_WE)
                    ref_mem[bus.D_ADDR[7:0]] = merge(ref_mem[bus.D_ADDR[7:0]], bus.D_WDATA, bus.D_WSTB);
            end
            last_c = ec;
            last_d = ed;
        end
    end

    // stimulus
    initial begin
        int          dn, dk;
        logic [13:0] tr;
        bit          cp, dp;
        int          cprob;

        c_set(0, 0, '0, '0, '0);
        d_set(0, 0, 0, '0, '0, '0);
        RSTN = 1'b0;
        tick;
        c_set(1, 0, 30'd3, '0, '0);
        @(negedge CLK);
        chk("reset_outputs", {bus.C_STALL, bus.C_GNT, bus.D_GNT, bus.CEM, bus.MWSTB,
                              bus.C_RVALID, bus.D_RVALID}, 10'b10_0000_0000);
        tick;
        c_set(0, 0, '0, '0, '0);
        RSTN = 1'b1;
        tick;

        // core read then byte-strobed write, then read back
        c_set(1, 0, 30'h40000, '0, '0);
        @(negedge CLK);
        chk("t1_rd_gnt", {bus.C_GNT, bus.CEM, bus.MWSTB}, 6'b11_0000);
        tick;
        c_set(1, 1, 30'h40000, 32'h11223344, 4'b0011);
        @(negedge CLK);
        chk("t1_rvalid", bus.C_RVALID, 1'b1);
        chk("t1_rdata", bus.RDATA, init_word(0));
        chk("t1_wr", {bus.C_GNT, bus.CEM, bus.MWSTB}, 6'b11_0011);
        tick;
        c_set(1, 0, 30'h40000, '0, '0);
        @(negedge CLK);
        chk("t1_wr_no_rvalid", bus.C_RVALID, 1'b0);
        tick;
        c_set(0, 0, '0, '0, '0);
        @(negedge CLK);
        chk("t1_readback", bus.RDATA, (init_word(0) & 32'hFFFF0000) | 32'h00003344);
        tick;

        // both requesting: DMA relieved exactly once in 12 cycles
        dn = 0; dk = 0;
        for (int k = 1; k <= 12; k++) begin
            c_set(1, 0, 30'd6, '0, '0);
            d_set(1, 0, 0, 30'd5, '0, '0);
            @(negedge CLK);
            if (bus.D_GNT) begin dn++; dk = k; end
            tick;
        end
        c_set(0, 0, '0, '0, '0);
        d_set(0, 0, 0, '0, '0, '0);
        chk("t2_d_count", dn, 1);
        chk("t2_d_cycle", dk, 9);
        tick;

        // locked burst caps at MAX_BURST, core gets one slot, DMA resumes
        tr = '0; cp = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            if (k == 2) cp = 1'b1;
            c_set(cp, 0, 30'd11, '0, '0);
            d_set(1, 1, (k < 7), 30'd10, 32'hD00D1234, 4'hF);
            @(negedge CLK);
            tr = {tr[11:0], bus.D_GNT ? 2'd2 : (bus.C_GNT ? 2'd1 : 2'd0)};
            if (bus.C_GNT) cp = 1'b0;
            tick;
        end
        c_set(0, 0, '0, '0, '0);
        d_set(0, 0, 0, '0, '0, '0);
        chk("t3_seq", tr, 14'b10_10_10_10_01_10_10);
        tick;

        // lock dropped at the second grant: core next, then plain arbitration
        d_set(1, 0, 1, 30'd20, '0, '0);
        @(negedge CLK);
        chk("t6_g1", {bus.C_GNT, bus.D_GNT}, 2'b01);
        tick;
        c_set(1, 0, 30'd21, '0, '0);
        d_set(1, 0, 0, 30'd22, '0, '0);
        @(negedge CLK);
        chk("t6_g2", {bus.C_GNT, bus.D_GNT}, 2'b01);
        tick;
        d_set(0, 0, 0, '0, '0, '0);
        @(negedge CLK);
        chk("t6_core_next", {bus.C_GNT, bus.D_GNT}, 2'b10);
        tick;
        c_set(1, 0, 30'd23, '0, '0);
        d_set(1, 0, 0, 30'd24, '0, '0);
        @(negedge CLK);
        chk("t6_arb", {bus.C_GNT, bus.D_GNT}, 2'b10);
        tick;
        c_set(0, 0, '0, '0, '0);
        tick;
        d_set(0, 0, 0, '0, '0, '0);
        tick;

        // reset with a DMA read in flight drops the response
        d_set(1, 0, 0, 30'd30, '0, '0);
        @(negedge CLK);
        chk("t4_d_gnt", bus.D_GNT, 1'b1);
        tick;
        d_set(0, 0, 0, '0, '0, '0);
        RSTN = 1'b0;
        @(negedge CLK);
        chk("t4_in_reset", {bus.D_RVALID, bus.C_RVALID, bus.C_GNT, bus.D_GNT, bus.CEM, bus.MWSTB}, 9'b0);
        tick;
        RSTN = 1'b1;
        @(negedge CLK);
        chk("t4_after", {bus.D_RVALID, bus.C_RVALID}, 2'b00);
        tick;

        // alternating core / DMA reads
        for (int k = 1; k <= 9; k++) begin
            if (k == 9) begin
                c_set(0, 0, '0, '0, '0);
                d_set(0, 0, 0, '0, '0, '0);
            end else if (k % 2 == 1) begin
                c_set(1, 0, 30'(40 + k), '0, '0);
                d_set(0, 0, 0, '0, '0, '0);
            end else begin
                c_set(0, 0, '0, '0, '0);
                d_set(1, 0, 0, 30'(40 + k), '0, '0);
            end
            @(negedge CLK);
            if (k >= 2) begin
                chk("t5_rvalid", {bus.D_RVALID, bus.C_RVALID}, (k % 2 == 0) ? 2'b01 : 2'b10);
                chk("t5_rdata", bus.RDATA, init_word(40 + k - 1));
            end
            tick;
        end

        // randomized traffic
        cp = 1'b0; dp = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (last_c) cp = 1'b0;
            if (last_d) dp = 1'b0;
            cprob = (n < 1500) ? 90 : 45;
            if (!cp && ($urandom_range(0, 99) < cprob)) begin
                cp = 1'b1;
                c_set(1, 1'($urandom_range(0, 1)), {22'($urandom), 8'($urandom_range(0, 63))},
                      $urandom, 4'($urandom_range(1, 15)));
            end
            if (!dp && ($urandom_range(0, 99) < 60)) begin
                dp = 1'b1;
                d_set(1, 1'($urandom_range(0, 1)), bus.D_LOCK,
                      {22'($urandom), 8'($urandom_range(0, 63))},
                      $urandom, 4'($urandom_range(1, 15)));
            end
            bus.C_REQ  = cp;
            bus.D_REQ  = dp;
            bus.D_LOCK = ($urandom_range(0, 99) < 55);
            RSTN       = ($urandom_range(0, 199) != 0);
            tick;
        end
        RSTN = 1'b1;
        c_set(0, 0, '0, '0, '0);
        d_set(0, 0, 0, '0, '0, '0);
        tick;
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
